// File: rtl/alu_seq_ctrl_if.sv
// Handshake and result bundle between the control logic and the ALU sequencer.
interface alu_seq_ctrl_if #(
    parameter int unsigned W = 8
) ();
    logic             start;
    logic [1:0]       op;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   result;
    logic             carry;
    logic             div_by_zero;
    logic [3:0]       sel;

    // Requester side: issues operations and observes results.
    modport master (
        output start, op, a, b,
        input  busy, done, result, carry, div_by_zero, sel
    );

    // Sequencer side.
    modport slave (
        input  start, op, a, b,
        output busy, done, result, carry, div_by_zero, sel
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle ALU sequencer: single-pass add/sub, shift-add multiply,
// restoring divide, plus a one-hot result-select code for downstream muxes.
module alu_seq_ctrl #(
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           rst,
    alu_seq_ctrl_if.slave  bus
);
    localparam int unsigned CW = $clog2(W) + 1;

    localparam logic [1:0] OpAdd = 2'b00;
    localparam logic [1:0] OpSub = 2'b01;
    localparam logic [1:0] OpMul = 2'b10;
    localparam logic [1:0] OpDiv = 2'b11;

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    // Multiplicand (shifted left each step); low half holds operand A for add/sub.
    logic [2*W-1:0]   mcand_q, mcand_d;
    // Multiplier (shifted right each step) for mul; divisor / operand B otherwise.
    logic [W-1:0]     opb_q, opb_d;
    // Product accumulator for mul; {remainder, quotient} for div.
    logic [2*W-1:0]   acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*W-1:0]   result_q, result_d;
    logic             carry_q, carry_d;
    logic             dbz_q, dbz_d;
    logic [3:0]       sel_q, sel_d;

    logic [W:0]       sum_ext;
    logic [W:0]       rem_ext;
    logic [W:0]       rem_sub;
    logic [W-1:0]     quot_sh;
    logic             last_iter;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            op_q     <= '0;
            mcand_q  <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            dbz_q    <= 1'b0;
            sel_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            mcand_q  <= mcand_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            dbz_q    <= dbz_d;
            sel_q    <= sel_d;
        end
    end

    // Next-state, iteration step and result capture.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        mcand_d  = mcand_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        carry_d  = carry_q;
        dbz_d    = dbz_q;
        sel_d    = sel_q;

        // Sub is a + ~b + 1; bit W is carry-out (1 = no borrow for sub).
        sum_ext   = {1'b0, mcand_q[W-1:0]}
                  + {1'b0, ((op_q == OpSub) ? ~opb_q : opb_q)}
                  + {{W{1'b0}}, (op_q == OpSub)};
        // Restoring-division step on the left-shifted {rem, quot}.
        rem_ext   = {acc_q[2*W-1:W], acc_q[W-1]};
        rem_sub   = rem_ext - {1'b0, opb_q};
        quot_sh   = {acc_q[W-2:0], 1'b0};
        last_iter = (cnt_q == CW'(W - 1));

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    sel_d   = 4'b0001 << bus.op;
                    carry_d = 1'b0;
                    dbz_d   = 1'b0;
                    cnt_d   = '0;
                    opb_d   = bus.b;
                    mcand_d = {{W{1'b0}}, bus.a};
                    if (bus.op == OpDiv && bus.b == '0) begin
                        // Divide by zero bypasses EXEC entirely.
                        result_d = {bus.a, {W{1'b1}}};
                        dbz_d    = 1'b1;
                        acc_d    = '0;
                        state_d  = StDone;
                    end else begin
                        acc_d   = (bus.op == OpDiv) ? {{W{1'b0}}, bus.a} : '0;
                        state_d = StExec;
                    end
                end
            end
            StExec: begin
                unique case (op_q)
                    OpAdd, OpSub: begin
                        result_d = {{W{1'b0}}, sum_ext[W-1:0]};
                        carry_d  = sum_ext[W];
                        state_d  = StDone;
                    end
                    OpMul: begin
                        if (opb_q[0]) begin
                            acc_d = acc_q + mcand_q;
                        end
                        mcand_d = mcand_q << 1;
                        opb_d   = opb_q; // multiplier shift below keeps divisor path untouched
                        opb_d   = opb_q >> 1;
                        cnt_d   = cnt_q + 1'b1;
                        if (last_iter) begin
                            result_d = acc_d;
                            state_d  = StDone;
                        end
                    end
                    default: begin // OpDiv
                        if (rem_ext >= {1'b0, opb_q}) begin
                            acc_d = {rem_sub[W-1:0], quot_sh | {{(W-1){1'b0}}, 1'b1}};
                        end else begin
                            acc_d = {rem_ext[W-1:0], quot_sh};
                        end
                        cnt_d = cnt_q + 1'b1;
                        if (last_iter) begin
                            result_d = acc_d;
                            state_d  = StDone;
                        end
                    end
                endcase
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.busy        = (state_q != StIdle);
    assign bus.done        = (state_q == StDone);
    assign bus.result      = result_q;
    assign bus.carry       = carry_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.sel         = sel_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a scoreboard of expected results.
module tb_alu_seq_ctrl;
    localparam int unsigned W = 8;

    typedef struct {
        logic [15:0] res;
        logic        carry;
        logic        dbz;
        logic [3:0]  sel;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    alu_seq_ctrl_if #(.W(W)) bus ();

    alu_seq_ctrl #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one op, wait for done, compare against the scoreboard head, then
    // spend the done cycle with start=hammer and confirm it is not accepted.
    task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          input bit hammer);
        exp_t e;
        exp_t got;
        logic [8:0] s;
        int n;
        bit busy_ok;
        e.carry = 1'b0;
        e.dbz   = 1'b0;
        e.sel   = 4'b0001 << op;
        e.lat   = W + 1;
        e.res   = '0;
        case (op)
            2'd0: begin
                s = {1'b0, a} + {1'b0, b};
                e.res = {8'h00, s[7:0]}; e.carry = s[8]; e.lat = 2;
            end
            2'd1: begin
                s = {1'b0, a} + {1'b0, ~b} + 9'd1;
                e.res = {8'h00, s[7:0]}; e.carry = s[8]; e.lat = 2;
            end
            2'd2: e.res = {8'h00, a} * {8'h00, b};
            default: begin
                if (b == 8'h00) begin
                    e.res = {a, 8'hFF}; e.dbz = 1'b1; e.lat = 1;
                end else begin
                    e.res = {a % b, a / b};
                end
            end
        endcase

        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        sb.push_back(e);
        @(posedge clk); #1;
        n = 0;
        busy_ok = 1'b1;
        while (bus.done !== 1'b1 && n < int'(W) + 4) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            bus.start = hammer;
            bus.op = 2'($urandom);
            bus.a  = 8'($urandom);
            bus.b  = 8'($urandom);
            @(posedge clk); #1;
            n++;
        end
        if (bus.busy !== 1'b1) busy_ok = 1'b0;
        got = sb.pop_front();
        check("done_seen", 32'(bus.done), 32'd1);
        check("latency", 32'(n + 1), 32'(got.lat));
        check("busy_during_op", 32'(busy_ok), 32'd1);
        check("result", 32'(bus.result), 32'(got.res));
        check("carry", 32'(bus.carry), 32'(got.carry));
        check("div_by_zero", 32'(bus.div_by_zero), 32'(got.dbz));
        check("sel", 32'(bus.sel), 32'(got.sel));

        @(negedge clk);
        bus.start = hammer;
        @(posedge clk); #1;
        check("done_one_pulse", 32'(bus.done), 32'd0);
        check("idle_after_done", 32'(bus.busy), 32'd0);
        check("result_hold", 32'(bus.result), 32'(got.res));
    endtask

    // Directed sequence.
    initial begin
        bit saw_done;
        bus.start = 1'b0; bus.op = 2'd0; bus.a = '0; bus.b = '0;
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_sel", 32'(bus.sel), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(2'd0, 8'hF0, 8'h20, 1'b0);
        run_op(2'd1, 8'h05, 8'h07, 1'b0);
        run_op(2'd2, 8'hFF, 8'hFF, 1'b0);
        run_op(2'd2, 8'h03, 8'h02, 1'b0);
        run_op(2'd3, 8'hC8, 8'h07, 1'b0);
        run_op(2'd3, 8'h03, 8'h09, 1'b0);
        run_op(2'd3, 8'h2A, 8'h00, 1'b0);
        run_op(2'd0, 8'h11, 8'h22, 1'b0);
        run_op(2'd2, 8'hA5, 8'h3C, 1'b1);
        run_op(2'd1, 8'h80, 8'h80, 1'b0);
        run_op(2'd3, 8'hFF, 8'h01, 1'b0);

        // Abort a multiply part-way through with an asynchronous reset.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'd2; bus.a = 8'h55; bus.b = 8'h33;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_result", 32'(bus.result), 32'd0);
        check("abort_carry", 32'(bus.carry), 32'd0);
        check("abort_dbz", 32'(bus.div_by_zero), 32'd0);
        check("abort_sel", 32'(bus.sel), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (W + 3) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) saw_done = 1'b1;
        end
        check("abort_no_done", 32'(saw_done), 32'd0);
        run_op(2'd0, 8'h7F, 8'h01, 1'b0);

        @(negedge clk);
        bus.start = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Multi-cycle ALU sequencer for the shared arithmetic datapath. It accepts one operation at a time through a start/busy/done handshake and performs the following operations:
- add and subtract in a single ripple-carry pass;
- unsigned multiply by iterative shift-add;
- unsigned divide by iterative restoring division.

It also drives a one-hot 4-way result-select code for downstream 4:1 one-hot mux instances. It sits between the instruction/control logic and the arithmetic units.

Parameters:
W, 8, operand width in bits (W >= 2); result width is 2*W; iteration counter width is clog2(W)+1.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active high
start  input  1  request; sampled only in IDLE
op  input  2  00 add, 01 sub, 10 mul, 11 div; captured with start
a  input  W  operand A (unsigned); captured with start
b  input  W  operand B (unsigned); captured with start
busy  output  1  high from the cycle after acceptance until DONE is left
done  output  1  one-cycle pulse; result valid
result  output  2W  add/sub: {W'b0, sum}; mul: product; div: {remainder, quotient}
carry  output  1  add: carry-out; sub: 1 = no borrow (a >= b); 0 for mul/div
div_by_zero  output  1  set on div with b == 0
sel  output  4  one-hot op code of the last accepted op: 0001 add, 0010 sub, 0100 mul, 1000 div

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, result=0, carry=0, div_by_zero=0, sel=0000; internal registers cleared. Reset mid-operation aborts immediately, with no done pulse and no partial result.
- States: IDLE, EXEC, DONE.
- IDLE: on an edge with start=1, latch op/a/b, set sel, clear carry and div_by_zero, go to EXEC. Exception: div with b==0 goes directly to DONE with quotient = all ones, remainder = a, div_by_zero=1.
- EXEC, add/sub:
  - one cycle; sum = a + b, or a + ~b + 1 for sub, computed W bits wide.
  - carry = bit W of the (W+1)-bit result.
  - go to DONE.
- EXEC, mul:
  - Start: acc = 0, multiplicand = a, multiplier = b.
  - Each cycle: if multiplier LSB = 1, acc += multiplicand << i. Then shift; i++.
  - Exactly W EXEC cycles, then DONE.
- EXEC, div:
  - Start: rem = 0, quot = a.
  - Each cycle: shift {rem, quot} left by 1; if rem >= b then rem -= b and quot LSB = 1.
  - Exactly W EXEC cycles, then DONE.
- DONE: done=1 for exactly one cycle, result/carry/div_by_zero valid; next state IDLE.
- result, carry, div_by_zero and sel hold their values until the next accepted start or reset.
- Result registers update only on the transition into DONE; intermediate values are never visible on result.
- busy = 1 in EXEC and DONE; 0 in IDLE.
- Latency, counted from the accepting edge (cycle 0):
  - add/sub: done at cycle 2;
  - mul/div: done at cycle W+1;
  - div-by-zero: done at cycle 1.
- start while busy=1 is ignored (not queued). start in the same cycle done=1 is also ignored. Back-to-back ops are therefore separated by at least one IDLE cycle.
- op, a, b may change freely after acceptance; the latched copies are used.
- All arithmetic is unsigned modulo 2^W per stage; the mul product never overflows 2W bits.

Test Plan:
1. Reset mid-op: assert rst during a mul EXEC -> outputs all zero immediately; no done; next start is accepted normally.
2. Add and sub (W=8):
   - add a=0xF0, b=0x20 -> done at cycle 2, result=0x0010, carry=1, sel=0001, busy high for cycles 1-2.
   - sub a=0x05, b=0x07 -> result=0x00FE, carry=0, sel=0010.
3. Multiply:
   - a=0xFF, b=0xFF -> done at cycle 9, result=0xFE01, sel=0100.
   - a=0x03, b=0x02 -> result=0x0006.
4. Divide:
   - a=0xC8 (200), b=0x07 -> done at cycle 9, quotient 0x1C, remainder 0x04, result=0x041C.
   - a=0x03, b=0x09 -> result=0x0300.
5. Divide by zero: a=0x2A, b=0 -> done at cycle 1, result=0x2AFF, div_by_zero=1. The next accepted add clears div_by_zero.
6. Handshake: pulse start repeatedly during a mul and in the done cycle -> exactly one done. Changing a/b after acceptance does not alter the result. A start one cycle after done is accepted.
